// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encodings and state helpers.
package program_loader_pkg;

    localparam logic [2:0] LDR_IDLE  = 3'd0;
    localparam logic [2:0] LDR_LOAD  = 3'd1;
    localparam logic [2:0] LDR_WRITE = 3'd2;
    localparam logic [2:0] LDR_RUN   = 3'd3;
    localparam logic [2:0] LDR_DONE  = 3'd4;
    localparam logic [2:0] LDR_ERROR = 3'd5;

    // States in which a start pulse is honoured.
    function automatic logic ldr_can_start(input logic [2:0] st);
        return (st == LDR_IDLE) || (st == LDR_DONE) || (st == LDR_ERROR);
    endfunction

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Packs host bytes MSB-first into a word; low bytes stay zero when a word is flushed early.
module program_loader_byte_assembler #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 accept,
    input  logic                 flush,
    input  logic [7:0]           byte_in,
    output logic [WORD_SIZE-1:0] word,
    output logic                 word_complete
);

    localparam int BYTES = WORD_SIZE / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [WORD_SIZE-1:0] shift_r;
    logic [IDX_W-1:0]     idx_r;
    logic [WORD_SIZE-1:0] word_s;
    logic                 complete_s;

    // Merge the incoming byte into its big-endian slot of the partial word.
    always_comb begin
        word_s = shift_r;
        for (int b = 0; b < BYTES; b++) begin
            if (idx_r == IDX_W'(b)) begin
                word_s[WORD_SIZE-1-8*b -: 8] = byte_in;
            end else begin
                word_s[WORD_SIZE-1-8*b -: 8] = shift_r[WORD_SIZE-1-8*b -: 8];
            end
        end
        complete_s = accept && (flush || (idx_r == IDX_W'(BYTES-1)));
    end

    assign word          = word_s;
    assign word_complete = complete_s;

    // Partial word and byte index; both return to zero once a word is handed off.
    always_ff @(posedge clock) begin
        if (!reset) begin
            shift_r <= {WORD_SIZE{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
        end else if (clear || complete_s) begin
            shift_r <= {WORD_SIZE{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
        end else if (accept) begin
            shift_r <= word_s;
            idx_r   <= idx_r + IDX_W'(1);
        end else begin
            shift_r <= shift_r;
            idx_r   <= idx_r;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: streams a host program into memory from address 0, then runs the cpu until halt.
// Optional feature macro LOADER_WATCHDOG_EN bounds the RUN phase to WATCHDOG_CYCLES cycles.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int WORD_SIZE       = 16,
    parameter int MEM_ADDR_SIZE   = 8,
    parameter int WATCHDOG_CYCLES = 4096
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     host_valid,
    input  logic [7:0]               host_data,
    input  logic                     host_last,
    output logic                     host_ready,
    output logic                     load_active,
    output logic [MEM_ADDR_SIZE-1:0] load_address,
    output logic [WORD_SIZE-1:0]     load_data,
    output logic                     load_write,
    output logic                     cpu_reset,
    output logic                     cpu_execute,
    input  logic                     cpu_halted,
    output logic [MEM_ADDR_SIZE:0]   words_loaded,
    output logic                     error,
    output logic [2:0]               state
);

    localparam logic [MEM_ADDR_SIZE-1:0] ADDR_MAX = {MEM_ADDR_SIZE{1'b1}};

    logic [2:0]           next_s;
    logic                 start_take_s;
    logic                 accept_s;
    logic                 word_done_s;
    logic [WORD_SIZE-1:0] word_s;
    logic                 last_r;
    logic                 wd_expired_s;

    // host_ready is only ever high in LOAD, so it alone qualifies acceptance.
    assign accept_s     = host_valid && host_ready;
    assign start_take_s = start && ldr_can_start(state);

    program_loader_byte_assembler #(
        .WORD_SIZE(WORD_SIZE)
    ) u_assembler (
        .clock        (clock),
        .reset        (reset),
        .clear        (start_take_s),
        .accept       (accept_s),
        .flush        (host_last),
        .byte_in      (host_data),
        .word         (word_s),
        .word_complete(word_done_s)
    );

`ifdef LOADER_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
    logic [WD_W-1:0] wd_r;

    // Counts RUN cycles; held at zero in every other state so it restarts on RUN entry.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wd_r <= {WD_W{1'b0}};
        end else if (state == LDR_RUN) begin
            wd_r <= wd_r + WD_W'(1);
        end else begin
            wd_r <= {WD_W{1'b0}};
        end
    end

    assign wd_expired_s = (state == LDR_RUN) && (wd_r == WD_W'(WATCHDOG_CYCLES - 1));
`else
    assign wd_expired_s = 1'b0;
`endif

    // Next-state decision for the loader FSM.
    always_comb begin
        next_s = state;
        case (state)
            LDR_IDLE, LDR_DONE, LDR_ERROR: begin
                if (start) next_s = LDR_LOAD;
                else       next_s = state;
            end
            LDR_LOAD: begin
                if (word_done_s) next_s = LDR_WRITE;
                else             next_s = LDR_LOAD;
            end
            LDR_WRITE: begin
                if (last_r)                      next_s = LDR_RUN;
                else if (load_address == ADDR_MAX) next_s = LDR_ERROR;
                else                             next_s = LDR_LOAD;
            end
            LDR_RUN: begin
                if (cpu_halted)        next_s = LDR_DONE;
                else if (wd_expired_s) next_s = LDR_ERROR;
                else                   next_s = LDR_RUN;
            end
            default: next_s = LDR_IDLE;
        endcase
    end

    // State, outputs decoded from the next state, and the address/word bookkeeping.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= LDR_IDLE;
            host_ready   <= 1'b0;
            load_active  <= 1'b0;
            load_write   <= 1'b0;
            load_address <= {MEM_ADDR_SIZE{1'b0}};
            load_data    <= {WORD_SIZE{1'b0}};
            cpu_reset    <= 1'b1;
            cpu_execute  <= 1'b0;
            words_loaded <= {(MEM_ADDR_SIZE+1){1'b0}};
            error        <= 1'b0;
            last_r       <= 1'b0;
        end else begin
            state       <= next_s;
            host_ready  <= (next_s == LDR_LOAD);
            load_active <= (next_s == LDR_LOAD) || (next_s == LDR_WRITE);
            load_write  <= (next_s == LDR_WRITE);
            cpu_execute <= (next_s == LDR_RUN);
            cpu_reset   <= (next_s != LDR_RUN) && (next_s != LDR_DONE);
            error       <= (next_s == LDR_ERROR);
            if (start_take_s) begin
                load_address <= {MEM_ADDR_SIZE{1'b0}};
                words_loaded <= {(MEM_ADDR_SIZE+1){1'b0}};
                last_r       <= 1'b0;
            end else if ((state == LDR_LOAD) && word_done_s) begin
                load_data <= word_s;
                last_r    <= host_last;
            end else if (state == LDR_WRITE) begin
                words_loaded <= words_loaded + (MEM_ADDR_SIZE+1)'(1);
                // The top address is terminal: either the program ends there or it overflows.
                if (load_address != ADDR_MAX) begin
                    load_address <= load_address + MEM_ADDR_SIZE'(1);
                end else begin
                    load_address <= load_address;
                end
            end else begin
                load_address <= load_address;
                words_loaded <= words_loaded;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a byte-stream/memory model.
module tb_program_loader;

    logic        clock = 1'b0;
    logic        reset, start, host_valid, host_last, cpu_halted;
    logic [7:0]  host_data;
    logic        host_ready, load_active, load_write, cpu_reset, cpu_execute, error;
    logic [7:0]  load_address;
    logic [15:0] load_data;
    logic [8:0]  words_loaded;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  prog_q[$];
    bit          send_last;
    logic [7:0]  wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          wr_cyc_q[$];

    always #5 clock = ~clock;

    program_loader dut (
        .clock(clock), .reset(reset), .start(start),
        .host_valid(host_valid), .host_data(host_data), .host_last(host_last),
        .host_ready(host_ready), .load_active(load_active), .load_address(load_address),
        .load_data(load_data), .load_write(load_write), .cpu_reset(cpu_reset),
        .cpu_execute(cpu_execute), .cpu_halted(cpu_halted), .words_loaded(words_loaded),
        .error(error), .state(state)
    );

    always @(posedge clock) cyc <= cyc + 1;

    // Memory-side monitor: every write strobe seen mid-cycle is one word written.
    always @(negedge clock) begin
        if (load_write === 1'b1) begin
            wr_addr_q.push_back(load_address);
            wr_data_q.push_back(load_data);
            wr_cyc_q.push_back(cyc);
        end
    end

    // Expected memory word i: bytes 2i and 2i+1 of the program, big-endian, missing bytes zero.
    function automatic logic [15:0] exp_word(input int i);
        logic [15:0] w;
        w = 16'h0000;
        for (int b = 0; b < 2; b++)
            if (2 * i + b < prog_q.size()) w = w | (16'(prog_q[2*i+b]) << (8 * (1 - b)));
        return w;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
    endtask

    task automatic send_prog(input int gap_pct, output int acc);
        int  idx;
        int  n;
        logic hr;
        idx = 0;
        n = 0;
        while (idx < prog_q.size() && n < 5000 && state !== 3'd5) begin
            host_valid = ($urandom_range(99) >= gap_pct);
            host_data  = prog_q[idx];
            host_last  = send_last && (idx == prog_q.size() - 1);
            hr = host_ready;
            tick();
            n++;
            if (hr && host_valid) idx++;
        end
        host_valid = 1'b0;
        host_last  = 1'b0;
        acc = idx;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
        int n;
        n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
        ok = (state === s);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({state, host_ready, load_active, load_write, load_address, load_data, cpu_reset,
             cpu_execute, words_loaded, error} !==
            {3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 9'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset state=%0d ready=%b wr=%b addr=%0d cpu_reset=%b exec=%b words=%0d err=%b",
                     state, host_ready, load_write, load_address, cpu_reset, cpu_execute, words_loaded, error);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_program(input string name, input int gap, input int run_cycles);
        int acc;
        int nw;
        int bad;
        bit ok;
        clear_log();
        pulse_start();
        checks++;
        if ({state, cpu_reset, cpu_execute, host_ready, load_active, error, words_loaded} !==
            {3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 9'd0}) begin
            errors++;
            $display("FAIL %s_start state=%0d cpu_reset=%b ready=%b err=%b words=%0d expected LOAD,1,1,0,0",
                     name, state, cpu_reset, host_ready, error, words_loaded);
        end
        send_prog(gap, acc);
        wait_state(3'd3, 20, ok);
        checks++;
        if (!ok || acc != prog_q.size()) begin
            errors++;
            $display("FAIL %s_reach_run state=%0d accepted=%0d expected RUN after %0d bytes",
                     name, state, acc, prog_q.size());
        end
        nw = (prog_q.size() + 1) / 2;
        checks++;
        if (wr_addr_q.size() != nw) begin
            errors++;
            $display("FAIL %s_write_count got %0d expected %0d", name, wr_addr_q.size(), nw);
        end
        bad = 0;
        for (int i = 0; i < wr_addr_q.size() && i < nw; i++)
            if (wr_addr_q[i] !== 8'(i) || wr_data_q[i] !== exp_word(i)) begin
                bad++;
                $display("FAIL %s_word%0d got [%0d]=%h expected [%0d]=%h",
                         name, i, wr_addr_q[i], wr_data_q[i], i, exp_word(i));
            end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if ({words_loaded, cpu_execute, cpu_reset, load_active, host_ready, error} !==
            {9'(nw), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s_run words=%0d exec=%b cpu_reset=%b active=%b ready=%b expected %0d,1,0,0,0",
                     name, words_loaded, cpu_execute, cpu_reset, load_active, host_ready, nw);
        end
        // Stray start and host bytes during RUN must change nothing.
        for (int k = 0; k < run_cycles; k++) begin
            start = (k == 3);
            host_valid = 1'b1;
            host_data = 8'($urandom);
            tick();
            start = 1'b0;
            host_valid = 1'b0;
        end
        if (run_cycles > 0) begin
            checks++;
            if (state !== 3'd3 || cpu_execute !== 1'b1 || wr_addr_q.size() != nw) begin
                errors++;
                $display("FAIL %s_run_hold state=%0d exec=%b writes=%0d expected RUN,1,%0d",
                         name, state, cpu_execute, wr_addr_q.size(), nw);
            end
        end
        cpu_halted = 1'b1;
        tick();
        cpu_halted = 1'b0;
        checks++;
        if ({state, cpu_execute, cpu_reset} !== {3'd4, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s_halt state=%0d exec=%b cpu_reset=%b expected DONE,0,0",
                     name, state, cpu_execute, cpu_reset);
        end
    endtask

    task automatic test_load_fixed();
        send_last = 1'b1;
        prog_q = '{8'h12, 8'h34, 8'h56, 8'h78};
        test_program("load4", 0, 0);
        checks++;
        if (wr_data_q.size() != 2 || wr_data_q[0] !== 16'h1234 || wr_data_q[1] !== 16'h5678) begin
            errors++;
            $display("FAIL load4_literal got %0d words expected 1234 5678", wr_data_q.size());
        end
        prog_q = '{8'hAB, 8'hCD, 8'hEF};
        test_program("odd", 20, 0);
        checks++;
        if (wr_data_q.size() != 2 || wr_data_q[1] !== 16'hEF00) begin
            errors++;
            $display("FAIL odd_pad got %0d words expected second word ef00", wr_data_q.size());
        end
    endtask

    task automatic test_random();
        send_last = 1'b1;
        for (int t = 0; t < 5; t++) begin
            int len;
            len = $urandom_range(1, 14);
            prog_q.delete();
            for (int i = 0; i < len; i++) prog_q.push_back(8'($urandom));
            test_program("random", 35, 0);
        end
    endtask

    task automatic test_halt();
        send_last = 1'b1;
        prog_q = '{8'hC3, 8'h5A};
        test_program("halt", 0, 10);
        pulse_start();
        checks++;
        if ({state, cpu_reset, cpu_execute, error, words_loaded} !== {3'd1, 1'b1, 1'b0, 1'b0, 9'd0}) begin
            errors++;
            $display("FAIL restart_from_done state=%0d cpu_reset=%b exec=%b words=%0d expected LOAD,1,0,0",
                     state, cpu_reset, cpu_execute, words_loaded);
        end
    endtask

    task automatic test_abort();
        // Loader is already in LOAD; one byte goes in, then reset hits mid-word.
        clear_log();
        host_valid = 1'b1;
        host_data = 8'h99;
        tick();
        host_valid = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({state, host_ready, load_active, cpu_reset, words_loaded} !== {3'd0, 1'b0, 1'b0, 1'b1, 9'd0}
            || wr_addr_q.size() != 0) begin
            errors++;
            $display("FAIL abort state=%0d ready=%b cpu_reset=%b words=%0d writes=%0d expected IDLE,0,1,0,0",
                     state, host_ready, cpu_reset, words_loaded, wr_addr_q.size());
        end
        send_last = 1'b1;
        prog_q = '{8'h12, 8'h34};
        test_program("fresh", 0, 0);
    endtask

    task automatic test_back_to_back();
        int bad;
        send_last = 1'b1;
        prog_q.delete();
        for (int i = 0; i < 10; i++) prog_q.push_back(8'($urandom));
        test_program("b2b", 0, 0);
        bad = 0;
        for (int i = 1; i < wr_cyc_q.size(); i++)
            if (wr_cyc_q[i] - wr_cyc_q[i-1] != 3) bad++;
        checks++;
        if (bad != 0 || wr_cyc_q.size() != 5) begin
            errors++;
            $display("FAIL b2b_throughput got %0d off-rate gaps over %0d writes expected 0 over 5",
                     bad, wr_cyc_q.size());
        end
    endtask

    task automatic test_overflow();
        int acc;
        int bad;
        bit ok;
        send_last = 1'b0;
        prog_q.delete();
        for (int i = 0; i < 514; i++) prog_q.push_back(8'($urandom));
        clear_log();
        pulse_start();
        send_prog(0, acc);
        wait_state(3'd5, 10, ok);
        checks++;
        if (!ok || wr_addr_q.size() != 256 || wr_addr_q[wr_addr_q.size()-1] !== 8'd255) begin
            errors++;
            $display("FAIL overflow_writes state=%0d writes=%0d expected ERROR after 256 writes ending at 255",
                     state, wr_addr_q.size());
        end
        bad = 0;
        for (int i = 0; i < wr_addr_q.size(); i++)
            if (wr_addr_q[i] !== 8'(i) || wr_data_q[i] !== exp_word(i)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL overflow_data got %0d wrong words expected 0", bad);
        end
        repeat (3) tick();
        checks++;
        if ({error, host_ready, load_active, cpu_reset, cpu_execute, words_loaded} !==
            {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'd256} || wr_addr_q.size() != 256) begin
            errors++;
            $display("FAIL overflow_state err=%b ready=%b cpu_reset=%b exec=%b words=%0d expected 1,0,1,0,256",
                     error, host_ready, cpu_reset, cpu_execute, words_loaded);
        end
        pulse_start();
        checks++;
        if ({state, error, words_loaded, load_address} !== {3'd1, 1'b0, 9'd0, 8'd0}) begin
            errors++;
            $display("FAIL restart_from_error state=%0d err=%b words=%0d addr=%0d expected LOAD,0,0,0",
                     state, error, words_loaded, load_address);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        host_valid = 1'b0;
        host_data = 8'h00;
        host_last = 1'b0;
        cpu_halted = 1'b0;
        send_last = 1'b1;
        test_reset();
        test_load_fixed();
        test_random();
        test_halt();
        test_abort();
        test_back_to_back();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
